eth_rx_ring: RTL and testbench

- Parametrised receive frame buffer for the Ethernet subsystem, in the byte-stream clock domain after the MAC's RX AXI-stream.
- Replaces the fixed eight-slot receive path with a configurable ring of NUM_BUF slots of BUF_BYTES each.
- Adds per-frame destination-MAC filtering and drop classification (runt, overrun, FCS/user error, ring full), with a saturating drop counter.
- The host reads frame bytes through a DATA_W-wide read port and releases slots explicitly; an interrupt is raised while any slot is occupied.

---
 rtl/eth_rx_pkg.sv | 43 ++++
 rtl/eth_rx_ring_if.sv | 36 +++
 rtl/eth_rx_bufmem.sv | 43 ++++
 rtl/eth_rx_ring.sv | 204 ++++++++++++++++++++
 tb/tb_eth_rx_ring.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types, constants and width helpers for the Ethernet receive ring.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        BODY,
        DROP
    } rx_state_e;

    // NONE marks "no drop decided this cycle"; every other value bumps drop_cnt.
    typedef enum logic [2:0] {
        NONE,
        RUNT,
        OVERRUN,
        ERR,
        FULL,
        FILTER
    } drop_rsn_e;

    localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;
    localparam logic [23:0] MCAST_IPV4_OUI = 24'h01_00_5E;
    localparam int          HDR_BYTES      = 6;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_w(input int bytes);
        return $clog2(bytes) + 1;
    endfunction

    function automatic int word_idx_w(input int bytes, input int dw);
        return idx_w(bytes * 8 / dw);
    endfunction

    // Group-address test: either any I/G bit, or only the IPv4 multicast OUI.
    function automatic logic is_group(input logic [47:0] d, input logic mcast_all);
        return mcast_all ? d[40] : (d[47:24] == MCAST_IPV4_OUI);
    endfunction

endpackage

// File: rtl/eth_rx_ring_if.sv
// RX byte stream plus host read/release port of the receive ring.
interface eth_rx_ring_if
    import eth_rx_pkg::*;
#(
    parameter int NUM_BUF   = 8,
    parameter int BUF_BYTES = 2048,
    parameter int DATA_W    = 64
);
    localparam int NB_W  = idx_w(NUM_BUF);
    localparam int RW_W  = word_idx_w(BUF_BYTES, DATA_W);
    localparam int LEN_W = len_w(BUF_BYTES);

    logic [7:0]        rx_tdata;
    logic              rx_tvalid;
    logic              rx_tlast;
    logic              rx_tuser;
    logic              rd_en;
    logic [NB_W-1:0]   rd_buf;
    logic [RW_W-1:0]   rd_word;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  rd_len;
    logic              release_i;

    modport master (
        output rx_tdata, rx_tvalid, rx_tlast, rx_tuser,
        output rd_en, rd_buf, rd_word, release_i,
        input  rd_data, rd_len
    );

    modport slave (
        input  rx_tdata, rx_tvalid, rx_tlast, rx_tuser,
        input  rd_en, rd_buf, rd_word, release_i,
        output rd_data, rd_len
    );

endinterface

// File: rtl/eth_rx_bufmem.sv
// Frame store: byte-wide write, DATA_W-wide registered read, one RAM per byte lane.
module eth_rx_bufmem #(
    parameter int NUM_BUF   = 8,
    parameter int BUF_BYTES = 2048,
    parameter int DATA_W    = 64,
    localparam int LANES    = DATA_W / 8,
    localparam int LB       = $clog2(LANES),
    localparam int DEPTH    = NUM_BUF * BUF_BYTES / LANES,
    localparam int AW       = $clog2(NUM_BUF * BUF_BYTES),
    localparam int WA_W     = $clog2(DEPTH)
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [WA_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Byte lane g holds every byte whose low address bits equal g.
        always_ff @(posedge clk_i) begin
            if (wr_en && (wr_addr[LB-1:0] == LB'(g)))
                mem[wr_addr[AW-1:LB]] <= wr_data;
        end

        // Registered read that holds its value while rd_en is low.
        always_ff @(posedge clk_i) begin
            if (!rst_ni)
                rd_q <= '0;
            else if (rd_en)
                rd_q <= mem[rd_addr];
        end

        assign rd_data[g*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/eth_rx_ring.sv
// Receive ring: filters and classifies incoming frames, stores good ones in
// NUM_BUF slots, and lets the host read and release them in order.
module eth_rx_ring
    import eth_rx_pkg::*;
#(
    parameter int NUM_BUF   = 8,
    parameter int BUF_BYTES = 2048,
    parameter int DATA_W    = 64,
    parameter int MCAST_ALL = 1,
    parameter int SYNC_IDLE = 16,
    localparam int NB_W     = idx_w(NUM_BUF)
)(
    input  logic            clk_i,
    input  logic            rst_ni,
    eth_rx_ring_if.slave    bus,
    input  logic [47:0]     mac_addr,
    input  logic            promiscuous,
    input  logic            irq_en,
    output logic [NB_W-1:0] head,
    output logic [NB_W-1:0] tail,
    output logic [NB_W:0]   count,
    output logic [15:0]     drop_cnt,
    output logic            irq_o
);

    localparam int BB_W  = $clog2(BUF_BYTES);
    localparam int CNT_W = len_w(BUF_BYTES);
    localparam int IC_W  = $clog2(SYNC_IDLE + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_OFS  = CNT_W'(BUF_BYTES - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BYTES - 1);
    localparam logic [IC_W-1:0]  IC_ONE    = IC_W'(1);
    localparam logic [IC_W-1:0]  SYNC_LAST = IC_W'(SYNC_IDLE - 1);
    localparam logic [NB_W:0]    CNT_FULL  = (NB_W + 1)'(NUM_BUF);
    localparam logic [NB_W:0]    COUNT_ONE = (NB_W + 1)'(1);
    localparam logic [NB_W-1:0]  PTR_ONE   = NB_W'(1);

    rx_state_e        state;
    drop_rsn_e        rsn;
    logic [CNT_W-1:0] cnt;
    logic [IC_W-1:0]  idle_cnt;
    logic [47:0]      dest;
    logic [47:0]      dest_nxt;
    logic             pass;
    logic             pass_nxt;
    logic [CNT_W-1:0] len [NUM_BUF];
    logic             wr_en;
    logic [BB_W-1:0]  wr_ofs;
    logic             commit;
    logic             rel;
    logic             full;

    assign full     = (count == CNT_FULL);
    assign rel      = bus.release_i && (count != '0);
    // Byte 0 of the frame ends up in dest[47:40] after six shifts.
    assign dest_nxt = {dest[39:0], bus.rx_tdata};
    assign pass_nxt = promiscuous
                    | (dest_nxt == mac_addr)
                    | (dest_nxt == MAC_BCAST)
                    | is_group(dest_nxt, MCAST_ALL != 0);

    // Per-byte decode: RAM write, drop decision and commit for this cycle.
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        rsn    = NONE;
        wr_ofs = cnt[BB_W-1:0];
        case (state)
            IDLE: begin
                wr_ofs = '0;
                if (bus.rx_tvalid) begin
                    if (full) begin
                        rsn = FULL;
                    end else begin
                        wr_en = 1'b1;
                        if (bus.rx_tlast) rsn = RUNT;
                    end
                end
            end
            HDR: begin
                if (bus.rx_tvalid) begin
                    wr_en = 1'b1;
                    if (bus.rx_tlast)
                        rsn = RUNT;
                    else if (cnt == HDR_LAST && !pass_nxt)
                        rsn = FILTER;
                end
            end
            BODY: begin
                if (bus.rx_tvalid) begin
                    wr_en = 1'b1;
                    if (!bus.rx_tlast && cnt == LAST_OFS)
                        rsn = OVERRUN;
                    else if (bus.rx_tlast) begin
                        if (bus.rx_tuser) rsn = ERR;
                        else              commit = pass;
                    end
                end
            end
            default: ;
        endcase
    end

    // Frame FSM; cnt restarts at 1 because byte 0 is written as the frame starts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= SYNC;
            idle_cnt <= '0;
            cnt      <= '0;
            dest     <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (bus.rx_tvalid) begin
                        idle_cnt <= '0;
                        if (bus.rx_tlast) state <= IDLE;
                    end else if (idle_cnt == SYNC_LAST) begin
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IC_ONE;
                    end
                end
                IDLE: begin
                    if (bus.rx_tvalid) begin
                        cnt  <= CNT_ONE;
                        dest <= dest_nxt;
                        pass <= 1'b0;
                        // A single-byte frame is already over; stay put.
                        if (!bus.rx_tlast) state <= (rsn == FULL) ? DROP : HDR;
                    end
                end
                HDR: begin
                    if (bus.rx_tvalid) begin
                        cnt  <= cnt + CNT_ONE;
                        dest <= dest_nxt;
                        if (bus.rx_tlast) begin
                            state <= IDLE;
                        end else if (cnt == HDR_LAST) begin
                            pass  <= pass_nxt;
                            state <= pass_nxt ? BODY : DROP;
                        end
                    end
                end
                BODY: begin
                    if (bus.rx_tvalid) begin
                        cnt <= cnt + CNT_ONE;
                        if (bus.rx_tlast)        state <= IDLE;
                        else if (rsn == OVERRUN) state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.rx_tvalid && bus.rx_tlast) state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end
    end

    // Ring bookkeeping: lengths, pointers, occupancy, drop counter, interrupt.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_BUF; i++) len[i] <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (commit) begin
                len[head] <= cnt + CNT_ONE;
                head      <= head + PTR_ONE;
            end
            if (rel) tail <= tail + PTR_ONE;
            case ({commit, rel})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: ;
            endcase
            if (rsn != NONE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            irq_o <= irq_en & (count != '0);
        end
    end

    assign bus.rd_len = len[bus.rd_buf];

    eth_rx_bufmem #(
        .NUM_BUF   (NUM_BUF),
        .BUF_BYTES (BUF_BYTES),
        .DATA_W    (DATA_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (wr_en),
        .wr_addr ({head, wr_ofs}),
        .wr_data (bus.rx_tdata),
        .rd_en   (bus.rd_en),
        .rd_addr ({bus.rd_buf, bus.rd_word}),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_eth_rx_ring.sv
// Scoreboard bench for eth_rx_ring: stimulus queues expectations, a negedge
// monitor pops them whenever a read returns or a status probe is raised.
module tb_eth_rx_ring;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] mac;
    logic        promisc;
    logic        irq_en;
    logic [2:0]  head;
    logic [2:0]  tail;
    logic [3:0]  count;
    logic [15:0] drop_cnt;
    logic        irq;

    always #5 clk = ~clk;

    eth_rx_ring_if #(.NUM_BUF(8), .BUF_BYTES(2048), .DATA_W(64)) bus ();

    eth_rx_ring #(
        .NUM_BUF(8), .BUF_BYTES(2048), .DATA_W(64), .MCAST_ALL(1), .SYNC_IDLE(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .mac_addr    (mac),
        .promiscuous (promisc),
        .irq_en      (irq_en),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .drop_cnt    (drop_cnt),
        .irq_o       (irq)
    );

    typedef enum {K_RD, K_RDQ, K_LEN, K_HEAD, K_TAIL, K_COUNT, K_DROP, K_IRQ} kind_e;
    typedef struct {
        kind_e       kind;
        logic [63:0] exp;
        int          step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;
    logic probe  = 1'b0;
    logic rd_vld = 1'b0;

    function automatic string kind_name(input kind_e k);
        case (k)
            K_RD:    return "rd_data";
            K_RDQ:   return "rd_data_idle";
            K_LEN:   return "rd_len";
            K_HEAD:  return "head";
            K_TAIL:  return "tail";
            K_COUNT: return "count";
            K_DROP:  return "drop_cnt";
            default: return "irq_o";
        endcase
    endfunction

    function automatic logic [7:0] fbyte(input logic [47:0] d, input int seed, input int i);
        if (i < 6) return d[47 - 8*i -: 8];
        return 8'(i + seed);
    endfunction

    function automatic logic [63:0] exp_word(input logic [47:0] d, input int seed, input int w);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = fbyte(d, seed, 8*w + k);
        return r;
    endfunction

    always @(posedge clk) rd_vld <= bus.rd_en;

    // Monitor: one expectation is consumed per returned read or status probe.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [63:0] act;
        if (rd_vld || probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL orphan: DUT output with empty scoreboard at step %0d", step);
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_RD, K_RDQ: act = bus.rd_data;
                    K_LEN:       act = 64'(bus.rd_len);
                    K_HEAD:      act = 64'(head);
                    K_TAIL:      act = 64'(tail);
                    K_COUNT:     act = 64'(count);
                    K_DROP:      act = 64'(drop_cnt);
                    default:     act = 64'(irq);
                endcase
                if (rd_vld != (e.kind == K_RD)) begin
                    errors++;
                    $display("FAIL order: step %0d expected %s but output kind differs", e.step, kind_name(e.kind));
                end else if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s step %0d: got %h want %h", kind_name(e.kind), e.step, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input kind_e k, input logic [63:0] v);
        sb.push_back('{k, v, step});
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic status(input int h, input int t, input int c, input int d);
        expect_val(K_HEAD,  64'(h));
        expect_val(K_TAIL,  64'(t));
        expect_val(K_COUNT, 64'(c));
        expect_val(K_DROP,  64'(d));
    endtask

    task automatic check_len(input int b, input int v);
        bus.rd_buf = 3'(b);
        expect_val(K_LEN, 64'(v));
    endtask

    task automatic do_read(input int b, input int w, input logic [63:0] v);
        bus.rd_buf  = 3'(b);
        bus.rd_word = 8'(w);
        bus.rd_en   = 1'b1;
        sb.push_back('{K_RD, v, step});
        tick();
        bus.rd_en = 1'b0;
        tick();
    endtask

    task automatic release_slot();
        bus.release_i = 1'b1;
        tick();
        bus.release_i = 1'b0;
    endtask

    // One byte per cycle; optional release on the tlast cycle and reset at byte rst_at.
    task automatic send_frame(input logic [47:0] d, input int len, input int seed,
                              input bit tuser, input bit rel_last, input int rst_at);
        for (int i = 0; i < len; i++) begin
            bus.rx_tvalid = 1'b1;
            bus.rx_tdata  = fbyte(d, seed, i);
            bus.rx_tlast  = (i == len - 1);
            bus.rx_tuser  = tuser && (i == len - 1);
            bus.release_i = rel_last && (i == len - 1);
            rst_n         = (i != rst_at);
            tick();
        end
        bus.rx_tvalid = 1'b0;
        bus.rx_tlast  = 1'b0;
        bus.rx_tuser  = 1'b0;
        bus.release_i = 1'b0;
        rst_n         = 1'b1;
        tick();
    endtask

    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST  = 48'h0100_5E00_0001;
    localparam logic [47:0] OTHER  = 48'h0200_0000_0001;

    initial begin
        rst_n         = 1'b0;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata  = '0;
        bus.rx_tlast  = 1'b0;
        bus.rx_tuser  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_buf    = '0;
        bus.rd_word   = '0;
        bus.release_i = 1'b0;
        mac           = 48'h2301_0089_0702;
        promisc       = 1'b0;
        irq_en        = 1'b1;
        repeat (3) tick();

        step = 1;   // reset state
        status(0, 0, 0, 0);
        expect_val(K_IRQ, 64'd0);
        check_len(0, 0);
        expect_val(K_RDQ, 64'd0);
        rst_n = 1'b1;
        repeat (20) tick();

        step = 2;   // unicast to station address
        send_frame(mac, 64, 0, 1'b0, 1'b0, -1);
        check_len(0, 64);
        status(1, 0, 1, 0);
        expect_val(K_IRQ, 64'd1);
        do_read(0, 0, 64'h0706_0207_8900_0123);
        do_read(0, 7, 64'h3F3E_3D3C_3B3A_3938);

        step = 3;   // broadcast
        send_frame(BCAST, 64, 1, 1'b0, 1'b0, -1);
        check_len(1, 64);
        status(2, 0, 2, 0);
        do_read(1, 0, 64'h0807_FFFF_FFFF_FFFF);

        step = 4;   // IPv4 multicast
        send_frame(MCAST, 70, 2, 1'b0, 1'b0, -1);
        check_len(2, 70);
        status(3, 0, 3, 0);

        step = 5;   // foreign unicast filtered
        send_frame(OTHER, 64, 3, 1'b0, 1'b0, -1);
        status(3, 0, 3, 1);

        step = 6;   // same frame, promiscuous
        promisc = 1'b1;
        send_frame(OTHER, 64, 3, 1'b0, 1'b0, -1);
        promisc = 1'b0;
        check_len(3, 64);
        status(4, 0, 4, 1);

        step = 7;   // 4-byte runt
        send_frame(mac, 4, 0, 1'b0, 1'b0, -1);
        status(4, 0, 4, 2);

        step = 8;   // overrun
        send_frame(mac, 2100, 0, 1'b0, 1'b0, -1);
        status(4, 0, 4, 3);
        check_len(4, 0);

        step = 9;   // tuser error
        send_frame(mac, 64, 0, 1'b1, 1'b0, -1);
        status(4, 0, 4, 4);

        step = 10;  // fill the remaining four slots
        for (int k = 0; k < 4; k++) send_frame(mac, 64, 10 + k, 1'b0, 1'b0, -1);
        status(0, 0, 8, 4);
        expect_val(K_IRQ, 64'd1);

        step = 11;  // ring full, release, refill slot 0
        send_frame(mac, 64, 0, 1'b0, 1'b0, -1);
        status(0, 0, 8, 5);
        release_slot();
        status(0, 1, 7, 5);
        send_frame(mac, 100, 8'h40, 1'b0, 1'b0, -1);
        check_len(0, 100);
        status(1, 1, 8, 5);
        do_read(0, 0, 64'h4746_0207_8900_0123);
        do_read(0, 11, 64'h9F9E_9D9C_9B9A_9998);

        step = 12;  // commit and release together
        release_slot();
        status(1, 2, 7, 5);
        send_frame(mac, 64, 0, 1'b0, 1'b1, -1);
        status(2, 3, 7, 5);
        check_len(1, 64);

        step = 13;  // drain, then release on empty ring
        repeat (7) release_slot();
        status(2, 2, 0, 5);
        expect_val(K_IRQ, 64'd0);
        release_slot();
        status(2, 2, 0, 5);

        step = 14;  // reset at byte 20, tail of frame discarded in SYNC
        send_frame(mac, 64, 5, 1'b0, 1'b0, 20);
        status(0, 0, 0, 0);
        check_len(0, 0);
        send_frame(mac, 64, 8'h20, 1'b0, 1'b0, -1);
        status(1, 0, 1, 0);
        check_len(0, 64);
        do_read(0, 1, exp_word(mac, 8'h20, 1));

        repeat (3) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d pending expectations want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
